frame_seq_ctrl: RTL and testbench

//  Parametrised readout frame sequencer between the sample FIFO and the CRC/framing stage.
//  Per event: SAMP_MAX+1 samples; each sample is DATA_WORDS FIFO words then TAIL_WORDS tail

---
 rtl/frame_seq_ctrl_pkg.sv | 38 +++
 rtl/frame_seq_ctrl_if.sv | 38 +++
 rtl/frame_seq_ctrl_tmr_vote.sv | 16 +
 rtl/frame_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_frame_seq_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/frame_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// frame_seq_pkg
// Shared definitions for the readout frame sequencer.
//   - state codes (as localparams and as the state_e enum built from them)
//   - state_name(): printable state name for simulation messages
// No ports (package).
// ----------------------------------------------------------------------------
package frame_seq_pkg;

    localparam logic [2:0] ST_CODE_IDLE    = 3'd0;
    localparam logic [2:0] ST_CODE_W4DATA  = 3'd1;
    localparam logic [2:0] ST_CODE_READ    = 3'd2;
    localparam logic [2:0] ST_CODE_TAIL    = 3'd3;
    localparam logic [2:0] ST_CODE_INCSMP  = 3'd4;
    localparam logic [2:0] ST_CODE_LASTWRD = 3'd5;

    typedef enum logic [2:0] {
        StIdle    = ST_CODE_IDLE,
        StW4Data  = ST_CODE_W4DATA,
        StRead    = ST_CODE_READ,
        StTail    = ST_CODE_TAIL,
        StIncSmp  = ST_CODE_INCSMP,
        StLastWrd = ST_CODE_LASTWRD
    } state_e;

    function automatic string state_name(input logic [2:0] code);
        case (code)
            ST_CODE_IDLE:    return "Idle";
            ST_CODE_W4DATA:  return "W4Data";
            ST_CODE_READ:    return "Read";
            ST_CODE_TAIL:    return "Tail";
            ST_CODE_INCSMP:  return "IncSmp";
            ST_CODE_LASTWRD: return "LastWrd";
            default:         return "Illegal";
        endcase
    endfunction

endpackage

// File: rtl/frame_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// frame_seq_ctrl_if
// Signal bundle between the frame sequencer and its surroundings.
//   master : the sequencer (drives RD, VALID, CLR_CRC, LAST_WRD, SEQ, SMP, FRM_STATE)
//   slave  : FIFO / L1A buffer / downstream side (drives L1A_BUF_MT, FAMT, FIFO_MT,
//            DS_RDY, SAMP_MAX)
// Parameters must match the ones given to frame_seq_ctrl.
// ----------------------------------------------------------------------------
interface frame_seq_ctrl_if #(
    parameter int unsigned DATA_WORDS = 96,
    parameter int unsigned TAIL_WORDS = 4,
    parameter int unsigned SMP_W      = 7
);
    localparam int unsigned SEQ_W = $clog2(DATA_WORDS + TAIL_WORDS);

    logic             L1A_BUF_MT;
    logic             FAMT;
    logic             FIFO_MT;
    logic             DS_RDY;
    logic [SMP_W-1:0] SAMP_MAX;
    logic             RD;
    logic             VALID;
    logic             CLR_CRC;
    logic             LAST_WRD;
    logic [SEQ_W-1:0] SEQ;
    logic [SMP_W-1:0] SMP;
    logic [2:0]       FRM_STATE;

    modport master (
        input  L1A_BUF_MT, FAMT, FIFO_MT, DS_RDY, SAMP_MAX,
        output RD, VALID, CLR_CRC, LAST_WRD, SEQ, SMP, FRM_STATE
    );

    modport slave (
        output L1A_BUF_MT, FAMT, FIFO_MT, DS_RDY, SAMP_MAX,
        input  RD, VALID, CLR_CRC, LAST_WRD, SEQ, SMP, FRM_STATE
    );
endinterface

// File: rtl/frame_seq_ctrl_tmr_vote.sv
// ----------------------------------------------------------------------------
// tmr_vote
// Bitwise 2-of-3 majority voter.
//   a, b, c : the three redundant copies (W bits each)
//   y       : voted value
// ----------------------------------------------------------------------------
module tmr_vote #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);
    assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/frame_seq_ctrl.sv
// ----------------------------------------------------------------------------
// frame_seq_ctrl
// Readout frame sequencer between the sample FIFO and the CRC/framing stage.
// Per event: SAMP_MAX+1 samples, each DATA_WORDS FIFO words followed by
// TAIL_WORDS tail words, with downstream backpressure and FIFO-empty stalling.
// Ports:
//   CLK  clock
//   RST  asynchronous, active-high reset
//   bus  frame_seq_ctrl_if.master: L1A_BUF_MT, FAMT, FIFO_MT, DS_RDY, SAMP_MAX in;
//        RD, VALID, CLR_CRC, LAST_WRD, SEQ, SMP, FRM_STATE out
// Build option:
//   FRAME_SEQ_TMR_EN  triplicates state, SEQ, SMP and latched SAMP_MAX with 2-of-3
//                     voting; each copy reloads from the voted next value every clock.
// ----------------------------------------------------------------------------
module frame_seq_ctrl
    import frame_seq_pkg::*;
#(
    parameter int unsigned DATA_WORDS = 96,
    parameter int unsigned TAIL_WORDS = 4,
    parameter int unsigned SMP_W      = 7
) (
    input logic              CLK,
    input logic              RST,
    frame_seq_ctrl_if.master bus
);
    localparam int unsigned      SEQ_W         = $clog2(DATA_WORDS + TAIL_WORDS);
    localparam logic [SEQ_W-1:0] SEQ_LAST_DATA = SEQ_W'(DATA_WORDS - 1);
    localparam logic [SEQ_W-1:0] SEQ_LAST_TAIL = SEQ_W'(DATA_WORDS + TAIL_WORDS - 1);

    state_e           st_v, st_d;
    logic [SEQ_W-1:0] seq_v, seq_d;
    logic [SMP_W-1:0] smp_v, smp_d;
    logic [SMP_W-1:0] smax_v, smax_d;

`ifdef FRAME_SEQ_TMR_EN
    (* keep = "true", preserve = "true" *) logic [2:0]       st_q   [3];
    (* keep = "true", preserve = "true" *) logic [SEQ_W-1:0] seq_q  [3];
    (* keep = "true", preserve = "true" *) logic [SMP_W-1:0] smp_q  [3];
    (* keep = "true", preserve = "true" *) logic [SMP_W-1:0] smax_q [3];

    // Every copy loads the voted next value, so an upset copy is scrubbed in one clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                st_q[i]   <= ST_CODE_IDLE;
                seq_q[i]  <= '0;
                smp_q[i]  <= '0;
                smax_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                st_q[i]   <= st_d;
                seq_q[i]  <= seq_d;
                smp_q[i]  <= smp_d;
                smax_q[i] <= smax_d;
            end
        end
    end

    logic [2:0] st_vote;

    tmr_vote #(.W(3)) u_vote_st (
        .a(st_q[0]), .b(st_q[1]), .c(st_q[2]), .y(st_vote)
    );
    tmr_vote #(.W(SEQ_W)) u_vote_seq (
        .a(seq_q[0]), .b(seq_q[1]), .c(seq_q[2]), .y(seq_v)
    );
    tmr_vote #(.W(SMP_W)) u_vote_smp (
        .a(smp_q[0]), .b(smp_q[1]), .c(smp_q[2]), .y(smp_v)
    );
    tmr_vote #(.W(SMP_W)) u_vote_smax (
        .a(smax_q[0]), .b(smax_q[1]), .c(smax_q[2]), .y(smax_v)
    );

    assign st_v = state_e'(st_vote);
`else
    logic [2:0]       st_q;
    logic [SEQ_W-1:0] seq_q;
    logic [SMP_W-1:0] smp_q;
    logic [SMP_W-1:0] smax_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q   <= ST_CODE_IDLE;
            seq_q  <= '0;
            smp_q  <= '0;
            smax_q <= '0;
        end else begin
            st_q   <= st_d;
            seq_q  <= seq_d;
            smp_q  <= smp_d;
            smax_q <= smax_d;
        end
    end

    assign st_v   = state_e'(st_q);
    assign seq_v  = seq_q;
    assign smp_v  = smp_q;
    assign smax_v = smax_q;
`endif

    logic adv_r, adv_t;
    logic rd, valid, clr_crc, last_wrd;

    assign adv_r = bus.DS_RDY & ~bus.FIFO_MT;
    assign adv_t = bus.DS_RDY;

    always_comb begin
        st_d     = st_v;
        seq_d    = seq_v;
        smp_d    = smp_v;
        smax_d   = smax_v;
        rd       = 1'b0;
        valid    = 1'b0;
        clr_crc  = 1'b0;
        last_wrd = 1'b0;
        case (st_v)
            StIdle: begin
                seq_d = '0;
                smp_d = '0;
                if (!bus.L1A_BUF_MT) begin
                    st_d   = StW4Data;
                    smax_d = bus.SAMP_MAX;
                end
            end
            StW4Data: begin
                clr_crc = 1'b1;
                if (!bus.FAMT) st_d = StRead;
            end
            StRead: begin
                rd    = adv_r;
                valid = adv_r;
                if (adv_r) begin
                    seq_d = seq_v + SEQ_W'(1);
                    if (seq_v == SEQ_LAST_DATA) st_d = StTail;
                end
            end
            StTail: begin
                valid = adv_t;
                if (adv_t) begin
                    seq_d = seq_v + SEQ_W'(1);
                    if (seq_v == SEQ_LAST_TAIL) st_d = StIncSmp;
                end
            end
            StIncSmp: begin
                clr_crc = 1'b1;
                seq_d   = '0;
                if (smp_v == smax_v) begin
                    st_d = StLastWrd;
                end else begin
                    smp_d = smp_v + SMP_W'(1);
                    st_d  = StRead;
                end
            end
            StLastWrd: begin
                last_wrd = 1'b1;
                st_d     = StIdle;
                seq_d    = '0;
                smp_d    = '0;
            end
            // Codes 6/7 can only come from an upset; recover through Idle.
            default: begin
                st_d  = StIdle;
                seq_d = '0;
                smp_d = '0;
            end
        endcase
    end

    assign bus.RD        = rd;
    assign bus.VALID     = valid;
    assign bus.CLR_CRC   = clr_crc;
    assign bus.LAST_WRD  = last_wrd;
    assign bus.SEQ       = seq_v;
    assign bus.SMP       = smp_v;
    assign bus.FRM_STATE = st_v;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_frame_seq_ctrl
// Directed self-checking bench for frame_seq_ctrl (DATA_WORDS=96, TAIL_WORDS=4).
// ----------------------------------------------------------------------------
module tb_frame_seq_ctrl;
    import frame_seq_pkg::*;

    localparam int unsigned DW = 96;
    localparam int unsigned TW = 4;
    localparam int unsigned SW = 7;
    localparam int          WPS = DW + TW;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    frame_seq_ctrl_if #(.DATA_WORDS(DW), .TAIL_WORDS(TW), .SMP_W(SW)) bus ();

    frame_seq_ctrl #(.DATA_WORDS(DW), .TAIL_WORDS(TW), .SMP_W(SW)) u_dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int ev_rd, ev_valid, ev_crc, ev_lw, ev_bad, xfer;
    bit rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        ev_rd    = 0;
        ev_valid = 0;
        ev_crc   = 0;
        ev_lw    = 0;
        ev_bad   = 0;
        xfer     = 0;
    endtask

    // One clock: sample at the falling edge, return 1 time unit after the rising edge.
    // Each transferred word is checked against a word-index model (SEQ, SMP, RD only on
    // data words, RD only with DS_RDY); deviations accumulate in ev_bad.
    task automatic cyc();
        @(negedge CLK);
        if (bus.VALID) begin
            if (int'(bus.SEQ) != xfer % WPS) ev_bad++;
            if (int'(bus.SMP) != xfer / WPS) ev_bad++;
            if (bus.RD != ((xfer % WPS) < DW)) ev_bad++;
            if (!bus.DS_RDY) ev_bad++;
            xfer++;
            ev_valid++;
        end else if (bus.RD) begin
            ev_bad++;
        end
        if (bus.RD) ev_rd++;
        if (bus.CLR_CRC) ev_crc++;
        if (bus.LAST_WRD) ev_lw++;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_event(input int budget);
        int n = 0;
        bus.L1A_BUF_MT = 1'b0;
        while (n < budget && !(ev_lw > 0 && bus.FRM_STATE == 3'd0)) begin
            if (rand_rdy) bus.DS_RDY = 1'($urandom_range(0, 1));
            cyc();
            n++;
            if (bus.FRM_STATE != 3'd0) bus.L1A_BUF_MT = 1'b1;
        end
        bus.L1A_BUF_MT = 1'b1;
        bus.DS_RDY     = 1'b1;
        check("event_back_to_idle", bus.FRM_STATE, 32'd0);
    endtask

    task automatic wait_until(input logic [2:0] st, input int seq, input int smp,
                              input int budget);
        int n = 0;
        bus.L1A_BUF_MT = 1'b0;
        while (n < budget && !(bus.FRM_STATE == st && int'(bus.SEQ) == seq
                               && int'(bus.SMP) == smp)) begin
            cyc();
            n++;
            if (bus.FRM_STATE != 3'd0) bus.L1A_BUF_MT = 1'b1;
        end
        bus.L1A_BUF_MT = 1'b1;
        check("wait_point_reached", 32'(n < budget), 32'd1);
    endtask

    task automatic check_event(input string tag, input int rd, input int vld, input int crc);
        check({tag, "_rd"},    ev_rd,    rd);
        check({tag, "_valid"}, ev_valid, vld);
        check({tag, "_crc"},   ev_crc,   crc);
        check({tag, "_lw"},    ev_lw,    1);
        check({tag, "_order"}, ev_bad,   0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST            = 1'b1;
        bus.L1A_BUF_MT = 1'b0;
        bus.FAMT       = 1'b0;
        bus.FIFO_MT    = 1'b0;
        bus.DS_RDY     = 1'b1;
        bus.SAMP_MAX   = '0;
        clear_counts();

        // Reset state, held with an event pending
        #1;
        check("rst_state", bus.FRM_STATE, 32'd0);
        check("rst_seq_smp", {bus.SEQ, bus.SMP}, 32'd0);
        check("rst_strobes", {bus.RD, bus.VALID, bus.CLR_CRC, bus.LAST_WRD}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst_hold_idle", bus.FRM_STATE, 32'd0);
        bus.L1A_BUF_MT = 1'b1;
        RST            = 1'b0;
        cyc();
        check("idle_no_event", bus.FRM_STATE, 32'd0);

        // 1: SAMP_MAX=7, full throughput
        bus.SAMP_MAX = 7'd7;
        clear_counts();
        run_event(2000);
        check_event("t1", 768, 800, 9);

        // 2: random downstream backpressure
        bus.SAMP_MAX = 7'd7;
        rand_rdy     = 1'b1;
        clear_counts();
        run_event(6000);
        rand_rdy = 1'b0;
        check_event("t2", 768, 800, 9);

        // 3: FIFO empty for 10 cycles at SEQ=40
        bus.SAMP_MAX = 7'd0;
        clear_counts();
        wait_until(ST_CODE_READ, 40, 0, 200);
        check("t3_rd_before_stall", ev_rd, 32'd40);
        bus.FIFO_MT = 1'b1;
        #1;
        check("t3_rd_low_in_stall", bus.RD, 32'd0);
        repeat (10) cyc();
        check("t3_seq_frozen", bus.SEQ, 32'd40);
        check("t3_rd_none_in_stall", ev_rd, 32'd40);
        check("t3_state_read", bus.FRM_STATE, 32'(ST_CODE_READ));
        bus.FIFO_MT = 1'b0;
        #1;
        check("t3_rd_resume", bus.RD, 32'd1);
        cyc();
        check("t3_seq_41", bus.SEQ, 32'd41);
        run_event(300);
        check_event("t3", 96, 100, 2);

        // 4: SAMP_MAX=0, changed to 5 mid-event; FAMT holds W4Data for 3 cycles
        bus.SAMP_MAX   = 7'd0;
        bus.FAMT       = 1'b1;
        clear_counts();
        bus.L1A_BUF_MT = 1'b0;
        cyc();
        bus.L1A_BUF_MT = 1'b1;
        bus.SAMP_MAX   = 7'd5;
        check("t4_w4data", bus.FRM_STATE, 32'(ST_CODE_W4DATA));
        check("t4_w4data_strobes", {bus.CLR_CRC, bus.RD, bus.VALID}, 32'b100);
        cyc();
        cyc();
        check("t4_famt_hold", bus.FRM_STATE, 32'(ST_CODE_W4DATA));
        bus.FAMT = 1'b0;
        run_event(300);
        check_event("t4", 96, 100, 4);

        // 5: reset in the middle of sample 3, then a full event
        bus.SAMP_MAX = 7'd7;
        clear_counts();
        wait_until(ST_CODE_READ, 50, 3, 2000);
        check("t5_rd_before_rst", bus.RD, 32'd1);
        RST = 1'b1;
        #1;
        check("t5_rst_strobes", {bus.RD, bus.VALID, bus.CLR_CRC, bus.LAST_WRD}, 32'd0);
        check("t5_rst_state", bus.FRM_STATE, 32'd0);
        check("t5_rst_seq_smp", {bus.SEQ, bus.SMP}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        clear_counts();
        run_event(2000);
        check_event("t5", 768, 800, 9);

`ifdef FRAME_SEQ_TMR_EN
        // 6: single-copy upset is masked and scrubbed
        bus.SAMP_MAX = 7'd0;
        clear_counts();
        wait_until(ST_CODE_READ, 10, 0, 200);
        u_dut.st_q[1]  = 3'd6;
        u_dut.seq_q[2] = 7'd99;
        #1;
        check("t6_state_masked", bus.FRM_STATE, 32'(ST_CODE_READ));
        check("t6_seq_masked", bus.SEQ, 32'd10);
        check("t6_rd_masked", bus.RD, 32'd1);
        cyc();
        check("t6_st_scrubbed", {u_dut.st_q[0], u_dut.st_q[1], u_dut.st_q[2]}, 32'o222);
        check("t6_seq_scrub1", u_dut.seq_q[1], 32'd11);
        check("t6_seq_scrub2", u_dut.seq_q[2], 32'd11);
        run_event(300);
        check_event("t6", 96, 100, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
